da_fir_sequencer: RTL and testbench

- Control sequencer for the distributed-arithmetic FIR datapath: 64-tap 16-bit sample delay line, bit-serial tap shift registers, LUT/accumulator.
- Accepts one input sample per valid/ready handshake. For each sample it:
  - pushes the sample into the delay line;
  - parallel-loads the tap shift registers;
  - clocks WIDTH serial bit cycles, MSB first;
  - drives accumulator clear, enable and sign-subtract controls;
  - flags output-valid.
- Sits between the sample source and the delay-line/shift-register/accumulator datapath, in the same clk domain.

---
 rtl/da_fir_sequencer.sv | 109 ++++++++++
 tb/tb_da_fir_sequencer.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/da_fir_sequencer.sv
// Control sequencer for the distributed-arithmetic FIR datapath: per accepted sample it pushes
// the delay line, loads the tap shift registers, then runs WIDTH MSB-first serial bit cycles.
module da_fir_sequencer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 5,
    parameter int unsigned OVR_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             run,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    output logic             s_ready,
    output logic [WIDTH-1:0] dl_data,
    output logic             dl_enable,
    output logic             sr_load,
    output logic             sr_shift,
    output logic             acc_clr,
    output logic             acc_en,
    output logic             acc_sub,
    output logic [CNT_W-1:0] bit_idx,
    output logic             y_valid,
    output logic             busy,
    output logic [OVR_W-1:0] overrun_cnt
);

    typedef enum logic [2:0] {StIdle, StPush, StLoad, StSerial, StDone} state_e;

    localparam logic [CNT_W-1:0] BitMsb = CNT_W'(WIDTH - 1);

    state_e state;
    logic   overrun;

    assign s_ready = (state == StIdle) && run;
    assign overrun = run && s_valid && !s_ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= StIdle;
            dl_data     <= '0;
            dl_enable   <= 1'b0;
            sr_load     <= 1'b0;
            sr_shift    <= 1'b0;
            acc_clr     <= 1'b0;
            acc_en      <= 1'b0;
            acc_sub     <= 1'b0;
            bit_idx     <= '0;
            y_valid     <= 1'b0;
            busy        <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            // Strobes default low; each state raises only what the following cycle needs.
            dl_enable <= 1'b0;
            sr_load   <= 1'b0;
            sr_shift  <= 1'b0;
            acc_clr   <= 1'b0;
            acc_en    <= 1'b0;
            acc_sub   <= 1'b0;
            y_valid   <= 1'b0;

            if (overrun && (overrun_cnt != {OVR_W{1'b1}})) begin
                overrun_cnt <= overrun_cnt + 1'b1;
            end

            case (state)
                StIdle: begin
                    if (s_valid && s_ready) begin
                        dl_data   <= s_data;
                        dl_enable <= 1'b1;
                        busy      <= 1'b1;
                        state     <= StPush;
                    end
                end
                StPush: begin
                    sr_load <= 1'b1;
                    acc_clr <= 1'b1;
                    state   <= StLoad;
                end
                StLoad: begin
                    // First serial cycle carries the sign weight, hence the subtract.
                    bit_idx  <= BitMsb;
                    sr_shift <= 1'b1;
                    acc_en   <= 1'b1;
                    acc_sub  <= 1'b1;
                    state    <= StSerial;
                end
                StSerial: begin
                    if (bit_idx == '0) begin
                        y_valid <= 1'b1;
                        state   <= StDone;
                    end else begin
                        bit_idx  <= bit_idx - 1'b1;
                        sr_shift <= 1'b1;
                        acc_en   <= 1'b1;
                    end
                end
                StDone: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_da_fir_sequencer.sv
// Self-checking bench for da_fir_sequencer: a phase-counter reference model feeds a scoreboard
// checked every negedge, plus directed scenario tasks with their own inline checks.
module tb_da_fir_sequencer;

    localparam int W = 16;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        run = 1'b0;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_ready;
    logic [15:0] dl_data;
    logic        dl_enable, sr_load, sr_shift, acc_clr, acc_en, acc_sub, y_valid, busy;
    logic [4:0]  bit_idx;
    logic [7:0]  overrun_cnt;

    int errors = 0;
    int checks = 0;

    da_fir_sequencer #(.WIDTH(16), .CNT_W(5), .OVR_W(8)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .run         (run),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .dl_data     (dl_data),
        .dl_enable   (dl_enable),
        .sr_load     (sr_load),
        .sr_shift    (sr_shift),
        .acc_clr     (acc_clr),
        .acc_en      (acc_en),
        .acc_sub     (acc_sub),
        .bit_idx     (bit_idx),
        .y_valid     (y_valid),
        .busy        (busy),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: m_ph counts cycles since acceptance (0 = idle).
    int          m_ph = 0;
    logic [4:0]  m_bit = '0;
    logic [7:0]  m_ovr = '0;
    logic        seen_rst = 1'b0;
    logic [15:0] exp_q[$];
    logic [8:0]  exp_v, act_v;
    logic [15:0] exp_d;

    always @(posedge clk) begin
        if (!resetn) begin
            m_ph     <= 0;
            m_bit    <= '0;
            m_ovr    <= '0;
            seen_rst <= 1'b1;
            exp_q.delete();
        end else begin
            if (run && s_valid && m_ph != 0 && m_ovr != 8'hff) m_ovr <= m_ovr + 8'd1;
            if (m_ph == 0) begin
                if (run && s_valid) begin
                    m_ph <= 1;
                    exp_q.push_back(s_data);
                end
            end else if (m_ph == W + 3) begin
                m_ph <= 0;
            end else begin
                m_ph <= m_ph + 1;
                if (m_ph + 1 >= 3 && m_ph + 1 <= W + 2) m_bit <= 5'(W + 2 - (m_ph + 1));
            end
        end
    end

    always @(negedge clk) begin
        if (seen_rst) begin
            exp_v = {m_ph == 1, m_ph == 2, m_ph == 2, m_ph >= 3 && m_ph <= W + 2,
                     m_ph >= 3 && m_ph <= W + 2, m_ph == 3, m_ph == W + 3, m_ph != 0,
                     m_ph == 0 && run};
            act_v = {dl_enable, sr_load, acc_clr, sr_shift, acc_en, acc_sub, y_valid, busy,
                     s_ready};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL strobes t=%0t: got %b expected %b", $time, act_v, exp_v);
            end
            checks++;
            if (bit_idx !== m_bit) begin
                errors++;
                $display("FAIL bit_idx t=%0t: got %0d expected %0d", $time, bit_idx, m_bit);
            end
            checks++;
            if (overrun_cnt !== m_ovr) begin
                errors++;
                $display("FAIL overrun t=%0t: got %0d expected %0d", $time, overrun_cnt, m_ovr);
            end
            if (dl_enable === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_dl t=%0t: got dl_enable expected no pending sample", $time);
                end else begin
                    exp_d = exp_q.pop_front();
                    if (dl_data !== exp_d) begin
                        errors++;
                        $display("FAIL sb_dl_data t=%0t: got %h expected %h", $time, dl_data,
                                 exp_d);
                    end
                end
            end
            checks++;
            if ((32'(dl_enable) + 32'(sr_load) + 32'(sr_shift)) > 1) begin
                errors++;
                $display("FAIL exclusive t=%0t: got %b%b%b expected at most one", $time,
                         dl_enable, sr_load, sr_shift);
            end
            checks++;
            if (acc_sub && !(acc_en && bit_idx == 5'd15)) begin
                errors++;
                $display("FAIL acc_sub t=%0t: got en=%b idx=%0d expected en=1 idx=15", $time,
                         acc_en, bit_idx);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(s_ready === 1'b1 && busy === 1'b0) && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 60) begin
            errors++;
            $display("FAIL wait_idle: got busy=%b s_ready=%b expected idle", busy, s_ready);
        end
    endtask

    task automatic test_reset();
        run = 1'b0;
        resetn = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if ({busy, y_valid, dl_enable, sr_load, sr_shift, acc_en, s_ready} !== 7'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b expected 0", {busy, y_valid, dl_enable,
                     sr_load, sr_shift, acc_en, s_ready});
        end
        checks++;
        if ({dl_data, bit_idx, overrun_cnt} !== 29'b0) begin
            errors++;
            $display("FAIL reset_regs: got %h/%0d/%0d expected 0", dl_data, bit_idx,
                     overrun_cnt);
        end
        resetn = 1'b1;
        run = 1'b1;
        tick();
    endtask

    task automatic test_single();
        wait_idle();
        s_data = 16'h8001;
        s_valid = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            s_valid = 1'b0;
            checks++;
            if (c == 1 && !(dl_enable === 1'b1 && dl_data === 16'h8001)) begin
                errors++;
                $display("FAIL single_push: got %b/%h expected 1/8001", dl_enable, dl_data);
            end else if (c == 2 && {sr_load, acc_clr, sr_shift} !== 3'b110) begin
                errors++;
                $display("FAIL single_load: got %b expected 110", {sr_load, acc_clr, sr_shift});
            end else if (c == 3 && {acc_sub, sr_shift, bit_idx} !== {2'b11, 5'd15}) begin
                errors++;
                $display("FAIL single_msb: got %b expected 1101111", {acc_sub, sr_shift, bit_idx});
            end else if (c >= 4 && c <= 18 &&
                         {acc_sub, sr_shift, acc_en, bit_idx} !== {3'b011, 5'(18 - c)}) begin
                errors++;
                $display("FAIL single_serial c=%0d: got %b expected %b", c,
                         {acc_sub, sr_shift, acc_en, bit_idx}, {3'b011, 5'(18 - c)});
            end else if (c == 19 && {y_valid, sr_shift, busy} !== 3'b101) begin
                errors++;
                $display("FAIL single_done: got %b expected 101", {y_valid, sr_shift, busy});
            end else if (c == 20 && {s_ready, busy, y_valid} !== 3'b100) begin
                errors++;
                $display("FAIL single_ready: got %b expected 100", {s_ready, busy, y_valid});
            end
        end
    endtask

    task automatic test_back_to_back();
        int y_cyc[$];
        int d_cyc[$];
        do_reset();
        wait_idle();
        s_data = 16'h1111;
        s_valid = 1'b1;
        for (int c = 1; c <= 59; c++) begin
            tick();
            if (dl_enable === 1'b1) begin
                d_cyc.push_back(c);
                s_data = s_data + 16'h1111;
            end
            if (y_valid === 1'b1) y_cyc.push_back(c);
        end
        tick();
        s_valid = 1'b0;
        checks++;
        if (d_cyc.size() != 3 || d_cyc[0] != 1 || d_cyc[1] != 21 || d_cyc[2] != 41) begin
            errors++;
            $display("FAIL b2b_accept: got %0d accepts expected 3 at 1,21,41", d_cyc.size());
        end
        checks++;
        if (y_cyc.size() != 3 || y_cyc[0] != 19 || y_cyc[1] != 39 || y_cyc[2] != 59) begin
            errors++;
            $display("FAIL b2b_yvalid: got %0d pulses expected 3 at 19,39,59", y_cyc.size());
        end
        checks++;
        if (overrun_cnt !== 8'd57 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_overrun: got %0d/%b expected 57/1", overrun_cnt, s_ready);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stop: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_run_drop();
        int ys = 0;
        int dls = 0;
        int rdy = 0;
        do_reset();
        wait_idle();
        s_data = 16'h7ffe;
        s_valid = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (c == 1) s_valid = 1'b0;
            if (c == 10) begin
                run = 1'b0;
                s_valid = 1'b1;
            end
            if (y_valid === 1'b1) ys += (c == 19) ? 1 : 100;
            if (c >= 2 && dl_enable === 1'b1) dls++;
            if (c >= 10 && s_ready !== 1'b0) rdy++;
        end
        checks++;
        if (ys != 1) begin
            errors++;
            $display("FAIL rundrop_y: got code %0d expected 1 (single pulse at 19)", ys);
        end
        checks++;
        if (dls != 0 || rdy != 0) begin
            errors++;
            $display("FAIL rundrop_hold: got dl=%0d rdy=%0d expected 0/0", dls, rdy);
        end
        checks++;
        if (overrun_cnt !== 8'd0) begin
            errors++;
            $display("FAIL rundrop_ovr: got %0d expected 0", overrun_cnt);
        end
        s_valid = 1'b0;
        run = 1'b1;
    endtask

    task automatic test_reset_mid();
        int ys = 0;
        wait_idle();
        s_data = 16'h0f0f;
        s_valid = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            s_valid = 1'b0;
        end
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        checks++;
        if ({dl_enable, sr_load, sr_shift, acc_en, acc_sub, acc_clr, y_valid, busy,
             bit_idx} !== 13'b0) begin
            errors++;
            $display("FAIL midreset: got %b expected 0", {dl_enable, sr_load, sr_shift,
                     acc_en, acc_sub, acc_clr, y_valid, busy, bit_idx});
        end
        for (int c = 0; c < 25; c++) begin
            tick();
            if (y_valid === 1'b1) ys++;
        end
        checks++;
        if (ys != 0) begin
            errors++;
            $display("FAIL midreset_y: got %0d pulses expected 0", ys);
        end
        s_data = 16'h1234;
        s_valid = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            s_valid = 1'b0;
            if (y_valid === 1'b1) ys += c;
        end
        checks++;
        if (ys != 19) begin
            errors++;
            $display("FAIL midreset_rerun: got y cycle %0d expected 19", ys);
        end
    endtask

    task automatic test_overrun_sat();
        int ys = 0;
        wait_idle();
        s_valid = 1'b1;
        for (int c = 1; c <= 6000; c++) begin
            tick();
            s_data = 16'(c);
            if (y_valid === 1'b1) ys++;
        end
        s_valid = 1'b0;
        checks++;
        if (overrun_cnt !== 8'd255) begin
            errors++;
            $display("FAIL ovr_sat: got %0d expected 255", overrun_cnt);
        end
        checks++;
        if (ys != 300) begin
            errors++;
            $display("FAIL ovr_seq: got %0d outputs expected 300", ys);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 2000; c++) begin
            s_valid = 1'($urandom_range(0, 1));
            run = ($urandom_range(0, 3) != 0);
            s_data = 16'($urandom);
            resetn = ($urandom_range(0, 499) != 0);
            tick();
        end
        resetn = 1'b1;
        run = 1'b1;
        s_valid = 1'b0;
        wait_idle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_drain: got %0d pending samples expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_run_drop();
        test_reset_mid();
        test_overrun_sat();
        test_random();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
